// File: rtl/i2s_receiver.sv
// i2s_receiver: I2S stereo capture into a clk-domain sample pair with decaying magnitude peaks
module i2s_receiver #(
    parameter int SAMPLE_W = 16,
    parameter int DECAY_SH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sclk,
    input  logic                lrck,
    input  logic                audio_sdout,
    input  logic                enable,
    input  logic                err_clr,
    input  logic                decay_tick,
    output logic [SAMPLE_W-1:0] sample_left,
    output logic [SAMPLE_W-1:0] sample_right,
    output logic                sample_valid,
    output logic [SAMPLE_W-2:0] peak_left,
    output logic [SAMPLE_W-2:0] peak_right,
    output logic                frame_err
);
    typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_t;

    localparam logic [5:0] LAST = 6'(SAMPLE_W - 1);

    state_t state, state_nx;
    logic [1:0] sclk_sync, lrck_sync, sd_sync;
    logic sclk_q, lrck_prev;
    logic bit_ev, lr_chg, slot_start, shift_en, word_done, err_set;
    logic [5:0] cnt;
    logic [SAMPLE_W-1:0] shreg, word, pend_l;
    logic chan, left_pend;
    logic [SAMPLE_W-2:0] mag_l, mag_r, dec_l, dec_r, pk_l_nx, pk_r_nx;

    function automatic logic [SAMPLE_W-2:0] mag(input logic [SAMPLE_W-1:0] x);
        logic [SAMPLE_W-1:0] n;
        n = x[SAMPLE_W-1] ? -x : x;
        return n[SAMPLE_W-1] ? {(SAMPLE_W-1){1'b1}} : n[SAMPLE_W-2:0];
    endfunction

    assign bit_ev = sclk_sync[1] & ~sclk_q;
    assign lr_chg = lrck_sync[1] ^ lrck_prev;
    assign word   = {shreg[SAMPLE_W-2:0], sd_sync[1]};

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // slot sequencing: an lrck change always opens a new slot, a change mid-word is a short slot
    always_comb begin
        state_nx   = state;
        slot_start = 1'b0;
        shift_en   = 1'b0;
        err_set    = 1'b0;
        if (!enable) begin
            state_nx = IDLE;
        end else if (bit_ev && lr_chg) begin
            slot_start = 1'b1;
            err_set    = state == CAPTURE;
            state_nx   = CAPTURE;
        end else if (bit_ev && state == CAPTURE) begin
            shift_en = 1'b1;
            state_nx = cnt == LAST ? HOLD : CAPTURE;
        end
        word_done = shift_en && cnt == LAST;
    end

    // input synchronizers and bit-event history
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            lrck_sync <= '0;
            sd_sync   <= '0;
            sclk_q    <= 1'b0;
            lrck_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk};
            lrck_sync <= {lrck_sync[0], lrck};
            sd_sync   <= {sd_sync[0], audio_sdout};
            sclk_q    <= sclk_sync[1];
            if (bit_ev) lrck_prev <= lrck_sync[1];
        end
    end

    // word assembly, left/right pairing and error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            shreg        <= '0;
            pend_l       <= '0;
            chan         <= 1'b0;
            left_pend    <= 1'b0;
            sample_left  <= '0;
            sample_right <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (err_set)      frame_err <= 1'b1;
            else if (err_clr) frame_err <= 1'b0;
            if (!enable) begin
                cnt       <= '0;
                shreg     <= '0;
                pend_l    <= '0;
                left_pend <= 1'b0;
            end else if (slot_start) begin
                chan  <= lrck_sync[1];
                cnt   <= '0;
                shreg <= '0;
                if (err_set) left_pend <= 1'b0;
            end else if (shift_en) begin
                shreg <= word;
                cnt   <= cnt + 6'd1;
                if (word_done && !chan) begin
                    pend_l    <= word;
                    left_pend <= 1'b1;
                end else if (word_done && left_pend) begin
                    sample_left  <= pend_l;
                    sample_right <= word;
                    sample_valid <= 1'b1;
                    left_pend    <= 1'b0;
                end
            end else if (bit_ev && state == HOLD && cnt != 6'h3f) begin
                cnt <= cnt + 6'd1;
            end
        end
    end

    // candidate peaks: fresh magnitude versus the (optionally decayed) held peak
    always_comb begin
        mag_l   = sample_valid ? mag(sample_left) : '0;
        mag_r   = sample_valid ? mag(sample_right) : '0;
        dec_l   = decay_tick ? peak_left - (peak_left >> DECAY_SH) : peak_left;
        dec_r   = decay_tick ? peak_right - (peak_right >> DECAY_SH) : peak_right;
        pk_l_nx = mag_l > dec_l ? mag_l : dec_l;
        pk_r_nx = mag_r > dec_r ? mag_r : dec_r;
    end

    // peak registers hold while capture is disabled
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_left  <= '0;
            peak_right <= '0;
        end else if (enable) begin
            peak_left  <= pk_l_nx;
            peak_right <= pk_r_nx;
        end
    end
endmodule
